output_limiter: RTL
===================

OUTPUT_LIMITER -- requirements
Module: output_limiter

Interface
REQ-001 SHALL provide parameter ATTACK_SHIFT, default 3, per-overshoot gain reduction as gain>>ATTACK_SHIFT.
REQ-002 SHALL provide parameter RELEASE_STEP, default 4, gain increment per sample in RELEASE.
REQ-003 SHALL provide parameter HOLD_SAMPLES, default 480, samples held after the last overshoot.
REQ-004 SHALL provide parameter GAIN_MIN, default 16'h0800, gain floor, Q1.15.
REQ-005 SHALL provide parameter MUTE_STEP, default 64, mute-ramp step per sample.
REQ-006 SHALL have one clock and an asynchronous active-low reset; ports are: clk  in  1  system clock (48 MHz); rst_n  in  1  async active-low reset.
REQ-007 Ports SHALL also include: sample_valid  in  1  one-cycle strobe for a new input sample; sample_in  in  16 signed  mixer output; threshold  in  15  peak limit magnitude.
REQ-008 Ports SHALL also include: mute_req  in  1  level mute request; sample_out  out  16 signed  limited sample to the I2S player.
REQ-009 Ports SHALL also include: out_valid  out  1  strobe for sample_out; limit_active  out  1  high when state != UNITY; gain  out  16  current gain, Q1.15; overshoot_count  out  16  saturating overshoot counter.

Function
REQ-010 Pipeline SHALL be 2 stages: out_valid pulses exactly 2 clk after sample_valid, and sample_out holds its value until the next out_valid.
REQ-011 Stage 1 SHALL compute product = sample_in × g (signed 16 × unsigned 16, 33-bit), using the g value registered in the cycle sample_valid is high.
REQ-012 Stage 2 SHALL compute sample_out = product >>> 15, saturated to [-32768, 32767].
REQ-013 Overshoot SHALL be defined as |product>>>15| > threshold, with |-32768| taken as 32767 and evaluated in stage 2.
REQ-014 FSM states SHALL be UNITY, ATTACK, HOLD and RELEASE, advancing only on stage-2 valid.
REQ-015 An overshoot in any state SHALL give: next = ATTACK; gain -= gain>>ATTACK_SHIFT, clamped at GAIN_MIN; hold_cnt = HOLD_SAMPLES; overshoot_count += 1, saturating at 16'hFFFF.
REQ-016 ATTACK with no overshoot SHALL go to HOLD.
REQ-017 HOLD SHALL decrement hold_cnt per sample and go to RELEASE when hold_cnt reaches 0.
REQ-018 RELEASE SHALL add RELEASE_STEP to gain per sample, saturating at 16'h8000, and go to UNITY when gain = 16'h8000.
REQ-019 UNITY with no overshoot SHALL hold gain at 16'h8000.
REQ-020 Back-to-back sample_valid (every cycle) SHALL be accepted; a gain update from sample n SHALL take effect from the first sample accepted after the stage-2 update (one-sample lag is permitted).
REQ-021 threshold = 0 SHALL drive gain to GAIN_MIN on any nonzero input; threshold ≥ 32767 SHALL never overshoot.
REQ-022 threshold changes SHALL take effect on the next stage-2 evaluation, with no glitch on sample_out.

Reset
REQ-023 rst_n low SHALL asynchronously set: gain = 16'h8000; state = UNITY; hold_cnt = 0; overshoot_count = 0; sample_out = 0; out_valid = 0; limit_active = 0; mute gain = 16'h8000.
REQ-024 Reset during operation SHALL discard in-flight samples, with no out_valid for them.
REQ-025 Release from reset SHALL be synchronised to clk (deassert over 2 flops).

Configuration
REQ-026 With LIMITER_SOFT_MUTE_EN defined: mute_gain SHALL ramp toward 0 by MUTE_STEP per accepted sample while mute_req = 1, and toward 16'h8000 while mute_req = 0, saturating at both ends.
REQ-027 With LIMITER_SOFT_MUTE_EN defined, g SHALL equal min(gain, mute_gain).
REQ-028 Without LIMITER_SOFT_MUTE_EN, g SHALL equal gain, and mute_req = 1 SHALL force sample_out = 0 on every out_valid; the mute_gain logic SHALL be absent.

Verification
REQ-029 Reset, then sample_in = 1000, threshold = 32767, 10 strobes -> sample_out = 1000 two clk after each strobe; gain = 16'h8000; limit_active = 0.
REQ-030 threshold = 8000, one sample of 16000 -> that sample's output = 16000; gain = 16'h7000; state ATTACK; overshoot_count = 1.
REQ-031 After REQ-030, feed 0s -> HOLD for 480 samples, then RELEASE; gain reaches 16'h8000 after 1024 further samples; limit_active then = 0.
REQ-032 Sustained full-scale -32768 with threshold = 0 -> gain settles at 16'h0800; outputs = -2048; overshoot_count increments on every sample.
REQ-033 LIMITER_SOFT_MUTE_EN defined, mute_req = 1, constant 16384 input -> output falls linearly to 0 over 512 samples; after deassert, returns to 16384 after 512 samples.
REQ-034 Assert rst_n low one cycle after sample_valid -> no out_valid; all outputs return to reset values immediately.

Source files
------------

// File: rtl/output_limiter_if.sv
// Sample-stream bundle between the mixer side and the output limiter.
// master drives samples and controls; slave is the limiter.
interface output_limiter_if;
    logic               sample_valid;
    logic signed [15:0] sample_in;
    logic        [14:0] threshold;
    logic               mute_req;
    logic signed [15:0] sample_out;
    logic               out_valid;
    logic               limit_active;
    logic        [15:0] gain;
    logic        [15:0] overshoot_count;

    modport master (
        output sample_valid, sample_in, threshold, mute_req,
        input  sample_out, out_valid, limit_active, gain, overshoot_count
    );

    modport slave (
        input  sample_valid, sample_in, threshold, mute_req,
        output sample_out, out_valid, limit_active, gain, overshoot_count
    );
endinterface

// File: rtl/output_limiter.sv
// Peak limiter with attack/hold/release gain control and a two-stage sample pipeline.
// Optional macro LIMITER_SOFT_MUTE_EN replaces the hard mute with a ramped mute gain.
module output_limiter #(
    parameter int unsigned ATTACK_SHIFT = 3,
    parameter int unsigned RELEASE_STEP = 4,
    parameter int unsigned HOLD_SAMPLES = 480,
    parameter logic [15:0] GAIN_MIN     = 16'h0800,
    parameter int unsigned MUTE_STEP    = 64
) (
    input logic              clk,
    input logic              rst_n,
    output_limiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_UNITY   = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [15:0] GAIN_UNITY = 16'h8000;
    localparam logic [15:0] HOLD_INIT  = 16'(HOLD_SAMPLES);
    localparam logic [16:0] REL_STEP17 = 17'(RELEASE_STEP);

    logic [1:0]         rst_sync_r;
    logic               run_s;
    logic [15:0]        g_s;
    logic signed [32:0] mul_a_s;
    logic signed [32:0] mul_b_s;
    logic signed [32:0] prod_r;
    logic               v1_r;
    logic               mute_zero_s;
    logic signed [17:0] shifted_s;
    logic signed [15:0] sat_s;
    logic signed [15:0] neg_s;
    logic        [14:0] mag_s;
    logic               overshoot_s;
    logic [15:0]        atk_s;
    logic [16:0]        rel_s;
    state_t             state_r;
    state_t             state_nx;
    logic [15:0]        gain_r;
    logic [15:0]        gain_nx;
    logic [15:0]        hold_r;
    logic [15:0]        hold_nx;
    logic [15:0]        cnt_r;
    logic [15:0]        cnt_nx;
    logic signed [15:0] sample_out_r;
    logic               out_valid_r;
    logic               limit_active_r;

    // Reset asserts at once but releases only after two clock edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign run_s = rst_sync_r[1];

`ifdef LIMITER_SOFT_MUTE_EN
    localparam logic [15:0] MUTE_STEP16 = 16'(MUTE_STEP);
    logic [15:0] mute_gain_r;

    // Mute gain ramps one step per accepted sample, saturating at 0 and unity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mute_gain_r <= GAIN_UNITY;
        end else if (!run_s) begin
            mute_gain_r <= GAIN_UNITY;
        end else if (bus.sample_valid) begin
            if (bus.mute_req) begin
                mute_gain_r <= (mute_gain_r > MUTE_STEP16) ? (mute_gain_r - MUTE_STEP16) : 16'h0000;
            end else begin
                mute_gain_r <= (mute_gain_r < (GAIN_UNITY - MUTE_STEP16)) ?
                               (mute_gain_r + MUTE_STEP16) : GAIN_UNITY;
            end
        end
    end

    // Effective gain is the smaller of limiter gain and mute gain
    always_comb begin
        g_s = gain_r;
        if (mute_gain_r < gain_r) begin
            g_s = mute_gain_r;
        end else begin
            g_s = gain_r;
        end
    end

    assign mute_zero_s = 1'b0;
`else
    logic mute1_r;

    // Hard mute request travels with its sample through the pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mute1_r <= 1'b0;
        end else if (!run_s) begin
            mute1_r <= 1'b0;
        end else if (bus.sample_valid) begin
            mute1_r <= bus.mute_req;
        end
    end

    assign g_s         = gain_r;
    assign mute_zero_s = mute1_r;
`endif

    assign mul_a_s = 33'(bus.sample_in);
    assign mul_b_s = $signed({17'h00000, g_s});

    // Stage 1: multiply the accepted sample by the gain in force at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r <= 33'sd0;
            v1_r   <= 1'b0;
        end else if (!run_s) begin
            prod_r <= 33'sd0;
            v1_r   <= 1'b0;
        end else begin
            v1_r <= bus.sample_valid;
            if (bus.sample_valid) begin
                prod_r <= mul_a_s * mul_b_s;
            end
        end
    end

    // Stage 2 datapath: rescale, saturate and measure magnitude against threshold
    always_comb begin
        shifted_s = prod_r[32:15];
        if (shifted_s > 18'sd32767) begin
            sat_s = 16'sh7FFF;
        end else if (shifted_s < -18'sd32768) begin
            sat_s = 16'sh8000;
        end else begin
            sat_s = shifted_s[15:0];
        end
        neg_s = -sat_s;
        if (sat_s == 16'sh8000) begin
            mag_s = 15'h7FFF;
        end else if (sat_s[15]) begin
            mag_s = neg_s[14:0];
        end else begin
            mag_s = sat_s[14:0];
        end
        overshoot_s = (mag_s > bus.threshold);
    end

    assign atk_s = gain_r - (gain_r >> ATTACK_SHIFT);
    assign rel_s = {1'b0, gain_r} + REL_STEP17;

    // Gain state machine; advances only when a sample completes stage 2
    always_comb begin
        state_nx = state_r;
        gain_nx  = gain_r;
        hold_nx  = hold_r;
        cnt_nx   = cnt_r;
        if (v1_r) begin
            if (overshoot_s) begin
                state_nx = ST_ATTACK;
                gain_nx  = (atk_s < GAIN_MIN) ? GAIN_MIN : atk_s;
                hold_nx  = HOLD_INIT;
                cnt_nx   = (cnt_r == 16'hFFFF) ? 16'hFFFF : (cnt_r + 16'd1);
            end else begin
                case (state_r)
                    ST_UNITY: begin
                        gain_nx = GAIN_UNITY;
                    end
                    ST_ATTACK: begin
                        state_nx = ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (hold_r <= 16'd1) begin
                            hold_nx  = 16'd0;
                            state_nx = ST_RELEASE;
                        end else begin
                            hold_nx = hold_r - 16'd1;
                        end
                    end
                    ST_RELEASE: begin
                        if (rel_s >= {1'b0, GAIN_UNITY}) begin
                            gain_nx  = GAIN_UNITY;
                            state_nx = ST_UNITY;
                        end else begin
                            gain_nx = rel_s[15:0];
                        end
                    end
                    default: begin
                        state_nx = ST_UNITY;
                        gain_nx  = GAIN_UNITY;
                        hold_nx  = 16'd0;
                    end
                endcase
            end
        end else begin
            state_nx = state_r;
        end
    end

    // Gain state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_UNITY;
            gain_r         <= GAIN_UNITY;
            hold_r         <= 16'd0;
            cnt_r          <= 16'd0;
            sample_out_r   <= 16'sd0;
            out_valid_r    <= 1'b0;
            limit_active_r <= 1'b0;
        end else if (!run_s) begin
            state_r        <= ST_UNITY;
            gain_r         <= GAIN_UNITY;
            hold_r         <= 16'd0;
            cnt_r          <= 16'd0;
            sample_out_r   <= 16'sd0;
            out_valid_r    <= 1'b0;
            limit_active_r <= 1'b0;
        end else begin
            state_r        <= state_nx;
            gain_r         <= gain_nx;
            hold_r         <= hold_nx;
            cnt_r          <= cnt_nx;
            out_valid_r    <= v1_r;
            limit_active_r <= (state_nx != ST_UNITY);
            if (v1_r) begin
                sample_out_r <= mute_zero_s ? 16'sd0 : sat_s;
            end
        end
    end

    assign bus.sample_out      = sample_out_r;
    assign bus.out_valid       = out_valid_r;
    assign bus.limit_active    = limit_active_r;
    assign bus.gain            = gain_r;
    assign bus.overshoot_count = cnt_r;

endmodule
